// File: rtl/ram_init_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_init_pkg
// Description : Shared types and default widths for the RAM initiator block.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_init_pkg;

    localparam int c_AW_DEFAULT = 4;
    localparam int c_DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'b00,
        OP_READ     = 2'b01,
        OP_FILL     = 2'b10,
        OP_CHECKSUM = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic logic op_is_read(input op_e op);
        return (op == OP_READ) || (op == OP_CHECKSUM);
    endfunction

endpackage : ram_init_pkg
`default_nettype wire

// File: rtl/ram_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_initiator_if
// Description : Host command/response and RAM bus signals of the initiator.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_initiator_if
    import ram_init_pkg::*;
#(
    parameter int AW = c_AW_DEFAULT,
    parameter int DW = c_DW_DEFAULT
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          done;
    logic          err;
    logic          mem_valid;
    logic          mem_wr_rd;
    logic [AW-1:0] mem_add;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;
    logic          mem_ready;

    // Initiator side
    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
        input  mem_readdata, mem_ready,
        output cmd_ready, rsp_valid, rsp_data, done, err,
        output mem_valid, mem_wr_rd, mem_add, mem_writedata
    );

    // Host plus RAM side
    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
        output mem_readdata, mem_ready,
        input  cmd_ready, rsp_valid, rsp_data, done, err,
        input  mem_valid, mem_wr_rd, mem_add, mem_writedata
    );

endinterface : ram_initiator_if
`default_nettype wire

// File: rtl/ram_init_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : ram_init_addr_gen
// Description : Start address and beat counter; yields the wrapping beat
//               address and a last-beat flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_init_addr_gen
    import ram_init_pkg::*;
#(
    parameter int AW = c_AW_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          load,
    input  wire logic [AW-1:0] start_addr,
    input  wire logic [AW-1:0] start_len,
    input  wire logic          advance,
    output logic [AW-1:0]      addr,
    output logic [AW-1:0]      beat,
    output logic               last_beat
);

    logic [AW-1:0] r_start;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start <= '0;
            r_len   <= '0;
            r_beat  <= '0;
        end else if (load) begin
            r_start <= start_addr;
            r_len   <= start_len;
            r_beat  <= '0;
        end else if (advance) begin
            r_beat  <= r_beat + 1'b1;
        end
    end

    // Sum truncates to AW bits, which gives the modulo-depth wrap.
    assign addr      = r_start + r_beat;
    assign beat      = r_beat;
    assign last_beat = (r_beat == r_len);

endmodule : ram_init_addr_gen
`default_nettype wire

// File: rtl/ram_initiator.sv
`default_nettype none
// ============================================================================
// Module      : ram_initiator
// Description : Host-driven RAM bus master: single/burst write, fill, read and
//               XOR checksum. Optional macro RAM_INIT_TIMEOUT_EN adds a
//               ready-timeout abort that raises err.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_initiator
    import ram_init_pkg::*;
#(
    parameter int AW      = c_AW_DEFAULT,
    parameter int DW      = c_DW_DEFAULT,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 15
) (
    input  wire logic      clk,
    input  wire logic      rst,
    ram_initiator_if.master bus
);

    localparam int c_LW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

    if (RD_LAT < 1 || TIMEOUT < 1) begin : g_param_check
        $error("ram_initiator: RD_LAT and TIMEOUT must be at least 1");
    end

    state_e          r_state;
    state_e          w_state_nxt;
    op_e             r_op;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   r_csum;
    logic [c_LW-1:0] r_lat_cnt;

    logic            w_accept;
    logic            w_load;
    logic            w_advance;
    logic            w_sample;
    logic            w_timeout;
    logic            w_abort;
    logic            w_rd_op;
    logic [AW-1:0]   w_addr;
    logic [AW-1:0]   w_beat;
    logic            w_last;
    logic [AW-1:0]   w_load_len;

    assign w_accept   = (r_state == IDLE) && bus.cmd_valid;
    assign w_rd_op    = op_is_read(r_op);
    assign w_sample   = (r_state == WAIT_RD) && (r_lat_cnt == c_LW'(RD_LAT - 1));
    // A WRITE is always a single beat regardless of cmd_len.
    assign w_load_len = (op_e'(bus.cmd_op) == OP_WRITE) ? '0 : bus.cmd_len;

    ram_init_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .start_addr (bus.cmd_addr),
        .start_len  (w_load_len),
        .advance    (w_advance),
        .addr       (w_addr),
        .beat       (w_beat),
        .last_beat  (w_last)
    );

`ifdef RAM_INIT_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT + 1);

    logic [c_TW-1:0] r_wait_cnt;
    logic            r_abort;

    assign w_timeout = (r_state == ISSUE) && !bus.mem_ready &&
                       (r_wait_cnt == c_TW'(TIMEOUT - 1));
    assign w_abort   = r_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_abort    <= 1'b0;
        end else begin
            if ((r_state == ISSUE) && !bus.mem_ready && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_accept) begin
                r_abort <= 1'b0;
            end else if (w_timeout) begin
                r_abort <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_abort   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= OP_WRITE;
            r_data    <= '0;
            r_csum    <= '0;
            r_lat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op   <= op_e'(bus.cmd_op);
                r_data <= bus.cmd_data;
                r_csum <= '0;
            end else if (w_sample && (r_op == OP_CHECKSUM)) begin
                r_csum <= r_csum ^ bus.mem_readdata;
            end
            if ((r_state == WAIT_RD) && !w_sample) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end else begin
                r_lat_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_load            = 1'b0;
        w_advance         = 1'b0;
        bus.cmd_ready     = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.rsp_data      = '0;
        bus.done          = 1'b0;
        bus.err           = 1'b0;
        bus.mem_valid     = 1'b0;
        bus.mem_wr_rd     = 1'b0;
        bus.mem_add       = '0;
        bus.mem_writedata = '0;

        case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                // Everything here derives from registered state, so it holds
                // steady for as long as mem_ready stays low.
                bus.mem_valid = 1'b1;
                bus.mem_wr_rd = !w_rd_op;
                bus.mem_add   = w_addr;
                if (r_op == OP_FILL) begin
                    bus.mem_writedata = r_data + DW'(w_beat);
                end else if (r_op == OP_WRITE) begin
                    bus.mem_writedata = r_data;
                end
                if (bus.mem_ready) begin
                    if (w_rd_op) begin
                        w_state_nxt = WAIT_RD;
                    end else if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = DONE;
                end
            end

            WAIT_RD: begin
                if (w_sample) begin
                    if (r_op == OP_READ) begin
                        bus.rsp_valid = 1'b1;
                        bus.rsp_data  = bus.mem_readdata;
                    end
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = ISSUE;
                    end
                end
            end

            DONE: begin
                bus.done = 1'b1;
                bus.err  = w_abort;
                if ((r_op == OP_CHECKSUM) && !w_abort) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_data  = r_csum;
                end
                w_state_nxt = IDLE;
            end

            default: w_state_nxt = IDLE;
        endcase
    end

endmodule : ram_initiator
`default_nettype wire

// File: tb/tb_ram_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_initiator
// Description : Directed bench for ram_initiator with a 16x8 RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_initiator;
    import ram_init_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_initiator_if #(.AW(4), .DW(8)) bus();

    ram_initiator #(
        .AW      (4),
        .DW      (8),
        .RD_LAT  (1),
        .TIMEOUT (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] tb_mem [16];

    // RAM model: one-cycle registered read, write on accepted beat.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= 8'h00;
            bus.mem_readdata <= 8'h00;
        end else if (bus.mem_valid && bus.mem_ready) begin
            if (bus.mem_wr_rd) tb_mem[bus.mem_add] <= bus.mem_writedata;
            else               bus.mem_readdata   <= tb_mem[bus.mem_add];
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] rsp_q [$];
    int         cyc;
    bit         got_err;
    int         both;
    bit         hung;
    int         moves;

    // Issue one command; ready held low for the first 'stall' cycles; with
    // 'poke' a stray WRITE stays on the command port while busy.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [3:0] len,
                           input logic [7:0] data, input int stall, input bit poke);
        logic [3:0] s_add;
        logic [7:0] s_wd;
        s_add = '0;
        s_wd  = '0;
        rsp_q.delete();
        cyc = 0; got_err = 0; both = 0; hung = 1; moves = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        bus.mem_ready = (stall == 0);
        @(posedge clk);
        #1;
        if (poke) begin
            bus.cmd_op   = 2'b00;
            bus.cmd_addr = 4'd9;
            bus.cmd_data = 8'h99;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 3) bus.cmd_valid = 1'b0;
            if (cyc <= stall) begin
                if (cyc == 1) begin
                    s_add = bus.mem_add;
                    s_wd  = bus.mem_writedata;
                end
                if (!bus.mem_valid || bus.mem_add != s_add || bus.mem_writedata != s_wd) moves++;
            end
            if (cyc == stall) bus.mem_ready = 1'b1;
            if (bus.rsp_valid) rsp_q.push_back(bus.rsp_data);
            if (bus.rsp_valid && bus.done) both++;
            if (bus.done) begin
                got_err = bus.err;
                hung    = 0;
                break;
            end
        end
        bus.mem_ready = 1'b1;
    endtask

    initial begin
        int n_rsp;
        int n_done;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("rst_cmd_ready", bus.cmd_ready, 1);
        check_vec("rst_mem_valid", bus.mem_valid, 0);
        check_vec("rst_done",      bus.done, 0);
        check_vec("rst_rsp_valid", bus.rsp_valid, 0);
        check_vec("rst_err",       bus.err, 0);
        check_vec("rst_mem_add",   bus.mem_add, 0);
        rst = 1'b0;

        // Single write then read-back
        run_cmd(2'b00, 4'd1, 4'd7, 8'h02, 0, 0);
        check_vec("wr_hang", hung, 0);
        check_vec("wr_latency", cyc, 2);
        check_vec("wr_nrsp", rsp_q.size(), 0);
        check_vec("wr_mem1", tb_mem[1], 8'h02);
        check_vec("wr_mem2_untouched", tb_mem[2], 8'h00);
        run_cmd(2'b01, 4'd1, 4'd0, 8'h00, 0, 0);
        check_vec("rd1_latency", cyc, 3);
        check_vec("rd1_nrsp", rsp_q.size(), 1);
        if (rsp_q.size() > 0) check_vec("rd1_data", rsp_q[0], 8'h02);
        check_vec("rd1_rsp_done_overlap", both, 0);

        // Fill across the wrap, then burst read
        run_cmd(2'b10, 4'd14, 4'd3, 8'h10, 0, 0);
        check_vec("fill_latency", cyc, 5);
        check_vec("fill_mem14", tb_mem[14], 8'h10);
        check_vec("fill_mem15", tb_mem[15], 8'h11);
        check_vec("fill_mem0",  tb_mem[0],  8'h12);
        check_vec("fill_mem1",  tb_mem[1],  8'h13);
        check_vec("fill_mem2",  tb_mem[2],  8'h00);
        run_cmd(2'b01, 4'd14, 4'd3, 8'h00, 0, 0);
        check_vec("rd4_latency", cyc, 9);
        check_vec("rd4_nrsp", rsp_q.size(), 4);
        check_vec("rd4_overlap", both, 0);
        if (rsp_q.size() == 4) begin
            check_vec("rd4_b0", rsp_q[0], 8'h10);
            check_vec("rd4_b1", rsp_q[1], 8'h11);
            check_vec("rd4_b2", rsp_q[2], 8'h12);
            check_vec("rd4_b3", rsp_q[3], 8'h13);
        end

        // Checksums
        run_cmd(2'b11, 4'd14, 4'd3, 8'h00, 0, 0);
        check_vec("cs0_latency", cyc, 9);
        check_vec("cs0_nrsp", rsp_q.size(), 1);
        check_vec("cs0_with_done", both, 1);
        if (rsp_q.size() > 0) check_vec("cs0_value", rsp_q[0], 8'h00);
        run_cmd(2'b00, 4'd0, 4'd0, 8'hFF, 0, 0);
        run_cmd(2'b11, 4'd14, 4'd3, 8'h00, 0, 0);
        check_vec("cs1_nrsp", rsp_q.size(), 1);
        if (rsp_q.size() > 0) check_vec("cs1_value", rsp_q[0], 8'hED);

        // Stalled fill beat
        run_cmd(2'b10, 4'd4, 4'd1, 8'h40, 5, 0);
        check_vec("stall_latency", cyc, 7);
        check_vec("stall_unstable", moves, 0);
        check_vec("stall_mem4", tb_mem[4], 8'h40);
        check_vec("stall_mem5", tb_mem[5], 8'h41);

        // Command presented while busy must be dropped
        run_cmd(2'b01, 4'd1, 4'd0, 8'h00, 0, 1);
        check_vec("busy_mem9", tb_mem[9], 8'h00);
        if (rsp_q.size() > 0) check_vec("busy_rd_data", rsp_q[0], 8'h13);
        @(negedge clk);
        check_vec("busy_idle_ready", bus.cmd_ready, 1);
        check_vec("busy_no_issue", bus.mem_valid, 0);

`ifdef RAM_INIT_TIMEOUT_EN
        run_cmd(2'b01, 4'd14, 4'd0, 8'h00, 1000, 0);
        check_vec("to_hang", hung, 0);
        check_vec("to_latency", cyc, 16);
        check_vec("to_err", got_err, 1);
        check_vec("to_nrsp", rsp_q.size(), 0);
        @(negedge clk);
        check_vec("to_cmd_ready", bus.cmd_ready, 1);
`else
        run_cmd(2'b01, 4'd14, 4'd0, 8'h00, 40, 0);
        check_vec("nto_latency", cyc, 42);
        check_vec("nto_err", got_err, 0);
        check_vec("nto_nrsp", rsp_q.size(), 1);
        if (rsp_q.size() > 0) check_vec("nto_data", rsp_q[0], 8'h10);
`endif

        // Reset in the middle of an 8-beat read (during beat 2)
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_addr  = 4'd0;
        bus.cmd_len   = 4'd7;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n_rsp = 0;
        for (int i = 0; i < 20 && n_rsp == 0; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rsp++;
        end
        check_vec("mid_first_rsp", n_rsp, 1);
        @(negedge clk);
        check_vec("mid_in_issue", bus.mem_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check_vec("mid_cmd_ready", bus.cmd_ready, 1);
        check_vec("mid_mem_valid", bus.mem_valid, 0);
        rst = 1'b0;
        n_rsp  = 0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rsp++;
            if (bus.done)      n_done++;
        end
        check_vec("mid_no_rsp", n_rsp, 0);
        check_vec("mid_no_done", n_done, 0);
        check_vec("mid_idle", bus.cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_ram_initiator
`default_nettype wire

// File: doc/ram_initiator.md
Name: ram_initiator

Overview:
- Bus master that drives the 16-entry x 8-bit RAM interface: valid, wr_rd, add, writedata, readdata, ready.
- Accepts one host command at a time and issues single or burst RAM accesses with wrap-around addressing.
- Returns read data or a burst XOR checksum to the host.
- Sits between the host/test controller and RAM8x16bit, so no other block needs to sequence RAM traffic by hand.

Parameters:
- AW, 4, address width; RAM depth is 2**AW.
- DW, 8, data width.
- RD_LAT, 1, cycles from an accepted read beat to valid mem_readdata.
- TIMEOUT, 15, max consecutive cycles with mem_ready low before abort (used only with the optional feature).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 WRITE, 01 READ, 10 FILL, 11 CHECKSUM.
- cmd_addr  in  AW  start address.
- cmd_len  in  AW  beats minus 1 (0..15 gives 1..16 beats); ignored for WRITE.
- cmd_data  in  DW  write data (WRITE) or fill seed (FILL).
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  DW  read beat data or final checksum.
- done  out  1  one-cycle pulse when a command completes or aborts.
- err  out  1  one-cycle pulse, coincident with done, on timeout abort; tied 0 without the optional feature.
- mem_valid  out  1  to RAM valid.
- mem_wr_rd  out  1  1 = write, 0 = read.
- mem_add  out  AW  to RAM add.
- mem_writedata  out  DW  to RAM writedata.
- mem_readdata  in  DW  from RAM readdata.
- mem_ready  in  1  from RAM ready.

Behaviour:
- Reset (rst=1 at posedge, takes priority over everything, including mid-burst):
  - State IDLE.
  - cmd_ready=1; all other outputs 0.
  - Internal address, beat count, checksum and wait counters cleared.
- States:
  - IDLE -> ISSUE on command accept; op, addr, len and data are latched.
  - ISSUE:
    - mem_valid=1; mem_add = current address; mem_wr_rd set per op; mem_writedata set per op.
    - A beat is accepted at a posedge where mem_ready=1.
    - If mem_ready=0, every mem_* output holds stable.
  - Write beat accepted:
    - If it was the last beat -> DONE; otherwise advance and stay in ISSUE.
  - Read beat accepted -> WAIT_RD:
    - mem_valid=0.
    - Count RD_LAT cycles, then sample mem_readdata.
    - READ: rsp_valid pulse with rsp_data = sample.
    - CHECKSUM: xor the sample into the accumulator.
    - Then -> ISSUE (more beats) or DONE (last beat).
  - DONE:
    - One cycle; done=1.
    - CHECKSUM: rsp_valid=1, rsp_data = accumulator (initial value 0).
    - -> IDLE.
- Ops:
  - WRITE: exactly one beat.
  - READ: len+1 beats, one rsp per beat.
  - FILL: beat i writes cmd_data + i (mod 2**DW).
  - CHECKSUM: len+1 read beats, one rsp at the end.
- Address increments by 1 per beat and wraps modulo 2**AW (15 -> 0).
- Latency at RD_LAT=1 and mem_ready=1:
  - WRITE: accept, ISSUE, DONE = 3 cycles to done.
  - Each read beat costs 2 cycles.
- cmd_valid while busy is ignored; the command is not latched.
- rsp_valid and done never coincide except on CHECKSUM/err completion.

Optional Feature:
- RAM_INIT_TIMEOUT_EN.
- Defined:
  - Counter increments each ISSUE cycle with mem_ready=0; cleared on beat accept.
  - On reaching TIMEOUT: -> DONE with err=1, mem_valid dropped, no rsp; remaining beats abandoned.
- Undefined: the counter does not exist, err is tied 0, and ISSUE waits on mem_ready indefinitely.

Decomposition:
- Package ram_init_pkg:
  - op enum (OP_WRITE, OP_READ, OP_FILL, OP_CHECKSUM).
  - State enum (IDLE, ISSUE, WAIT_RD, DONE).
  - Default AW/DW constants.
- Sub-module ram_init_addr_gen: latched start address plus beat counter.
  - Outputs current address (wrapping) and last_beat.
  - Instantiated once.
- All remaining logic lives in a single FSM in ram_initiator.

Test Plan:
- WRITE addr=1 data=0x02, then READ addr=1 len=0 -> one rsp_valid with rsp_data=0x02, then done; RAM entry 1 = 0x02.
- FILL addr=14 seed=0x10 len=3 -> writes 14:0x10, 15:0x11, 0:0x12, 1:0x13 (wrap); READ addr=14 len=3 returns the same 4 values in order.
- CHECKSUM over the previous range -> single rsp_data = 0x10^0x11^0x12^0x13 = 0x00. Then WRITE addr=0 data=0xFF and re-run -> rsp_data = 0xED.
- Hold mem_ready=0 for 5 cycles during a FILL beat -> mem_add and mem_writedata are stable throughout; the beat completes when ready returns.
- Assert rst mid-READ burst (beat 2 of 8) -> next cycle IDLE, mem_valid=0, cmd_ready=1, no further rsp_valid or done.
- With RAM_INIT_TIMEOUT_EN and mem_ready held 0 -> after 15 cycles done=1 and err=1 on the same cycle, then cmd_ready=1.
